ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port system RAM between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the processor's fetch/memory stages and the cpu_ram_if RAM port.
- Sequences one RAM access at a time and gives data priority, with a starvation guard for fetch.
- Aborts accesses that exceed a timeout and flags the error.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- STARVE_LIMIT, 4, consecutive data grants (while fetch waits) after which fetch is forced through; must be 1..15.
- TIMEOUT, 255, cycles an access may wait for ramready before it is aborted; must be 1..255.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- iREN  in  1  fetch read request; held until iwait is low.
- iaddr  in  ADDR_W  fetch address; stable while iREN is high.
- iload  out  DATA_W  fetch read data; valid in the completion cycle.
- iwait  out  1  high while a fetch request is pending and not complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; overrides dREN if both are high.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  data read data; valid in the completion cycle.
- dwait  out  1  high while a data request is pending and not complete.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramready  in  1  RAM reports that the current access completes this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- FSM states:
  - IDLE: no RAM access; arbitration happens here.
  - IACC: fetch access in progress.
  - DACC: data access in progress.
- Reset:
  - State goes to IDLE; dstreak=0, tcnt=0, err=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iload=dload=0; iwait=iREN, dwait=(dREN|dWEN).
- Reset asserted mid-access abandons the access at that edge. RAM enables are 0 in the next cycle, and no completion is signalled.
- Arbitration in IDLE (registered transition):
  - Data requested and not (iREN and dstreak==STARVE_LIMIT): go to DACC. dstreak increments if iREN, else clears to 0.
  - Else if iREN: go to IACC; dstreak clears to 0.
  - Else stay in IDLE.
- In IDLE, all RAM enables are 0 and both wait outputs equal their request inputs.
- IACC outputs: ramREN=1, ramaddr=iaddr, ramWEN=0, ramstore=0. dwait follows the data request.
- DACC outputs: ramaddr=daddr.
  - dWEN=1: ramWEN=1, ramREN=0, ramstore=dstore.
  - Otherwise: ramREN=1.
  - iwait=iREN.
- Completion: in IACC/DACC with ramready=1, the owning wait goes low for exactly that cycle.
  - Owning load = ramload, combinational; dload is don't-care (driven ramload) for writes.
  - Next state is IDLE; tcnt clears.
- Non-owning load outputs are 0.
- Minimum latency from request to completion is 2 cycles (IDLE grant, then access with ramready). The back-to-back same-requester rate is 1 access per 2 cycles.
- Timeout: tcnt (8 bits) increments each access cycle with ramready=0.
  - Cycle where tcnt==TIMEOUT-1 and ramready=0: abort. Owning wait goes low, owning load = 32'hBAD1BAD1, err is set at the next edge, next state is IDLE.
  - err stays set until RST.
- Requests dropped mid-access (protocol violation): the FSM finishes or times out normally; wait outputs follow the rule "request & not complete".
- Simultaneous events: ramready and timeout in the same cycle counts as normal completion, no error. Request inputs are ignored outside IDLE except for wait outputs.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1 → ramREN=ramWEN=0, err=0, iwait=1, state IDLE. After release, grant to IACC on the first edge.
- Fetch read: iREN=1, iaddr=0x40, RAM ready after 3 access cycles with ramload=0x12345678 → ramREN=1 and ramaddr=0x40 for 3 cycles; iwait low for 1 cycle with iload=0x12345678.
- Data write priority: iREN and dWEN rise together, daddr=0x80, dstore=0xDEADBEEF → DACC first with ramWEN=1, ramstore=0xDEADBEEF; IACC follows after completion.
- Starvation: iREN held, dREN re-requested continuously, ramready=1 each access cycle → exactly 4 data completions, then 1 fetch completion, then data resumes; dstreak=1 after the first resumed grant.
- Timeout: dREN=1, ramready tied 0 → dwait drops on the 255th access cycle with dload=0xBAD1BAD1; err=1 and stays 1 across later good accesses until RST.
- Reset mid-access: assert RST on the 2nd cycle of a DACC → next cycle ramREN=ramWEN=0, no completion pulse, dstreak=0.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between instruction fetch and data requesters
// Data has priority; a streak counter forces fetch through, and stalled accesses time out.
module ram_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ramready,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

   localparam logic [DATA_W-1:0] BAD_LOAD = DATA_W'(32'hBAD1BAD1);

   state_t      r_state, w_next;
   logic [3:0]  r_dstreak, w_dstreak_next;
   logic [7:0]  r_tcnt, w_tcnt_next;
   logic        r_err;
   logic        w_dreq, w_timeout, w_set_err;
   logic [DATA_W-1:0] w_result;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_dstreak <= 4'd0;
         r_tcnt    <= 8'd0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_dstreak <= w_dstreak_next;
         r_tcnt    <= w_tcnt_next;
         r_err     <= r_err | w_set_err;
      end
   end

   assign err       = r_err;
   assign w_dreq    = dREN | dWEN;
   assign w_timeout = (r_tcnt == 8'(TIMEOUT - 1)) && !ramready;
   // A ready RAM wins over a simultaneous timeout.
   assign w_result  = ramready ? ramload : BAD_LOAD;

   always_comb begin
      w_next         = r_state;
      w_dstreak_next = r_dstreak;
      w_tcnt_next    = r_tcnt;
      w_set_err      = 1'b0;
      ramREN         = 1'b0;
      ramWEN         = 1'b0;
      ramaddr        = '0;
      ramstore       = '0;
      iload          = '0;
      dload          = '0;
      iwait          = iREN;
      dwait          = w_dreq;
      // While RST is high the outputs show the idle view regardless of state.
      if (!RST) begin
         case (r_state)
            IDLE: begin
               if (w_dreq && !(iREN && r_dstreak == 4'(STARVE_LIMIT))) begin
                  w_next         = DACC;
                  w_dstreak_next = iREN ? r_dstreak + 4'd1 : 4'd0;
               end else if (iREN) begin
                  w_next         = IACC;
                  w_dstreak_next = 4'd0;
               end
            end
            IACC: begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramready || w_timeout) begin
                  iwait       = 1'b0;
                  iload       = w_result;
                  w_set_err   = !ramready;
                  w_next      = IDLE;
                  w_tcnt_next = 8'd0;
               end else begin
                  w_tcnt_next = r_tcnt + 8'd1;
               end
            end
            DACC: begin
               ramaddr  = daddr;
               ramWEN   = dWEN;
               ramREN   = !dWEN;
               ramstore = dWEN ? dstore : '0;
               if (ramready || w_timeout) begin
                  dwait       = 1'b0;
                  dload       = w_result;
                  w_set_err   = !ramready;
                  w_next      = IDLE;
                  w_tcnt_next = 8'd0;
               end else begin
                  w_tcnt_next = r_tcnt + 8'd1;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ram_arbiter;
   localparam int STARVE  = 4;
   localparam int TMO     = 255;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN, ramready;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN, err;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .err(err)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // RAM agent: ready after 'lat' access cycles (0 = never), random ready noise when idle
   int          lat = 1;
   int          acc_cnt = 0;
   logic [31:0] load_val = 32'h0;

   always @(posedge CLK) begin
      #2;
      if (ramREN || ramWEN) begin
         acc_cnt++;
         ramready = (lat != 0) && (acc_cnt >= lat);
      end else begin
         acc_cnt  = 0;
         ramready = 1'($urandom_range(0, 1));
      end
      ramload = load_val;
   end

   // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), grant streak, access age
   int          m_owner = 0, m_streak = 0, m_cyc = 0;
   bit          m_err = 0, m_valid = 0;
   bit          m_fin, seen_idone = 0, seen_ddone = 0;
   logic        e_ren, e_wen, e_iw, e_dw, m_dq;
   logic [31:0] e_addr, e_st, e_il, e_dl, m_res;
   int          log_q[$];

   always @(negedge CLK) begin
      m_dq   = dREN | dWEN;
      e_ren  = 0; e_wen = 0; e_addr = 0; e_st = 0; e_il = 0; e_dl = 0;
      e_iw   = iREN; e_dw = m_dq; m_fin = 0;
      if (!RST && m_owner != 0) begin
         m_fin = ramready || (m_cyc == TMO - 1);
         m_res = ramready ? ramload : 32'hBAD1BAD1;
         if (m_owner == 1) begin
            e_ren = 1; e_addr = iaddr;
            if (m_fin) begin e_iw = 0; e_il = m_res; end
         end else begin
            e_ren = !dWEN; e_wen = dWEN; e_addr = daddr; e_st = dWEN ? dstore : 32'h0;
            if (m_fin) begin e_dw = 0; e_dl = m_res; end
         end
      end
      check("ramREN", ramREN, e_ren);
      check("ramWEN", ramWEN, e_wen);
      check("ramaddr", ramaddr, e_addr);
      check("ramstore", ramstore, e_st);
      check("iload", iload, e_il);
      check("dload", dload, e_dl);
      check("iwait", iwait, e_iw);
      check("dwait", dwait, e_dw);
      if (m_valid) check("err", err, m_err);
      seen_idone = !RST && iREN && !iwait;
      seen_ddone = !RST && m_dq && !dwait;
      if (seen_idone) log_q.push_back(1);
      if (seen_ddone) log_q.push_back(2);
      if (RST) begin
         m_owner = 0; m_streak = 0; m_cyc = 0; m_err = 0; m_valid = 1;
      end else if (m_owner == 0) begin
         if (m_dq && !(iREN && m_streak == STARVE)) begin
            m_owner = 2; m_streak = iREN ? m_streak + 1 : 0;
         end else if (iREN) begin
            m_owner = 1; m_streak = 0;
         end
      end else if (m_fin) begin
         if (!ramready) m_err = 1;
         m_owner = 0; m_cyc = 0;
      end else begin
         m_cyc++;
      end
   end

   task automatic wait_done(input bit fetch, input int limit,
                            output int acc, output logic [31:0] ld, output logic [31:0] st);
      bit got = 0;
      acc = 0; ld = 0; st = 0;
      for (int n = 0; n < limit && !got; n++) begin
         @(negedge CLK);
         if (ramREN || ramWEN) acc++;
         if (fetch ? (iREN && !iwait) : ((dREN | dWEN) && !dwait)) begin
            got = 1; ld = fetch ? iload : dload; st = ramstore;
         end
      end
      if (!got) check(fetch ? "fetch_done_bound" : "data_done_bound", 32'd0, 32'd1);
      @(posedge CLK); #1;
   endtask

   int          acc;
   logic [31:0] ld, st;

   initial begin
      RST = 1; iREN = 1; dREN = 0; dWEN = 0; ramready = 0; ramload = 0;
      iaddr = 32'h40; daddr = 0; dstore = 0; lat = 3; load_val = 32'h12345678;
      @(negedge CLK);
      check("rst_ramREN", ramREN, 0);
      check("rst_iwait", iwait, 1);
      @(negedge CLK);
      check("rst_err", err, 0);
      @(posedge CLK); #1 RST = 0;

      // fetch read, ready on third access cycle
      wait_done(1, 20, acc, ld, st);
      check("fetch_acc_cycles", acc, 3);
      check("fetch_iload", ld, 32'h12345678);
      iREN = 0;

      // simultaneous fetch and data write: data goes first
      log_q.delete();
      iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; lat = 2;
      wait_done(0, 20, acc, ld, st);
      check("wr_ramstore", st, 32'hDEADBEEF);
      dWEN = 0;
      wait_done(1, 20, acc, ld, st);
      iREN = 0;
      check("prio_count", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         check("prio_first_data", log_q[0], 2);
         check("prio_then_fetch", log_q[1], 1);
      end

      // starvation guard: continuous data traffic with a waiting fetch
      log_q.delete();
      iREN = 1; dREN = 1; iaddr = 32'h48; daddr = 32'h84; lat = 1;
      for (int n = 0; n < 200 && log_q.size() < 10; n++) @(posedge CLK);
      #1 iREN = 0; dREN = 0;
      if (log_q.size() < 10) check("starve_bound", log_q.size(), 10);
      else for (int k = 0; k < 10; k++)
         check("starve_order", log_q[k], (k % (STARVE + 1) == STARVE) ? 1 : 2);
      repeat (4) @(posedge CLK);
      #1;

      // timeout on a data read
      dREN = 1; daddr = 32'h100; lat = 0;
      wait_done(0, 400, acc, ld, st);
      check("tmo_cycles", acc, TMO);
      check("tmo_dload", ld, 32'hBAD1BAD1);
      dREN = 0;
      @(negedge CLK);
      check("tmo_err_set", err, 1);
      @(posedge CLK); #1 dREN = 1; lat = 2;
      wait_done(0, 20, acc, ld, st);
      dREN = 0;
      @(negedge CLK);
      check("err_sticky", err, 1);

      // reset during the second cycle of a data access
      @(posedge CLK); #1 dREN = 1; lat = 0;
      @(posedge CLK); @(posedge CLK); #1 RST = 1;
      @(negedge CLK);
      check("rstmid_ramREN", ramREN, 0);
      check("rstmid_dwait", dwait, 1);
      @(posedge CLK); #1 RST = 0; lat = 1;
      @(negedge CLK);
      check("rstmid_err_clr", err, 0);
      check("rstmid_no_done", dwait, 1);
      @(posedge CLK); #1;
      wait_done(0, 20, acc, ld, st);
      dREN = 0;

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         @(posedge CLK); #1;
         if (seen_idone) iREN = 0;
         if (seen_ddone) begin dREN = 0; dWEN = 0; end
         if (!iREN && $urandom_range(0, 2) == 0) begin
            iREN = 1; iaddr = $urandom;
         end
         if (!dREN && !dWEN && $urandom_range(0, 2) == 0) begin
            dWEN = 1'($urandom_range(0, 1));
            dREN = dWEN ? 1'($urandom_range(0, 1)) : 1'b1;
            daddr = $urandom; dstore = $urandom;
         end
         lat = $urandom_range(1, 4);
         load_val = $urandom;
         RST = ($urandom_range(0, 199) == 0);
      end
      RST = 0; iREN = 0; dREN = 0; dWEN = 0;
      repeat (6) @(posedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
